wb_stage: RTL and testbench

Write-back stage of the 16-bit pipeline, directly downstream of the memory stage. Latches the memory stage's outputs into a MEM/WB pipeline register, selects the write-back value, and commits it into a 16×16 register file. The register file has two bypassed read ports for the decode stage. The block also exports the in-flight write for forwarding, tracks a sticky halt, and counts retired instructions.

---
 rtl/wb_stage.sv | 69 ++++++
 tb/tb_wb_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, write-back select, bypassed 16x16 register file, halt flag and retire counter
module wb_stage (
  input  logic        clk,
  input  logic        rest,
  input  logic        SpecialChangeMEMWB,
  input  logic        FlushMEMWB,
  input  logic [15:0] Controll_Signal_In,
  input  logic [15:0] Read1_In,
  input  logic [15:0] AluOrMem_In,
  input  logic [15:0] Adder_Result_In,
  input  logic [3:0]  Rd_In,
  input  logic [3:0]  Ra_Addr,
  input  logic [3:0]  Rb_Addr,
  output logic [15:0] Ra_Data,
  output logic [15:0] Rb_Data,
  output logic        Wb_Enable,
  output logic [3:0]  Wb_Rd,
  output logic [15:0] Wb_Data,
  output logic        Halted,
  output logic [15:0] Retired_Count
);
  logic [15:0] ctrl_q, r1_q, am_q, add_q, cnt_q;
  logic [3:0]  rd_q;
  logic [15:0] rf_q [16];
  logic        halt_q, commit;
  always_comb begin
    Wb_Data   = ctrl_q[2:1] == 2'b00 ? am_q :
                ctrl_q[2:1] == 2'b01 ? add_q :
                ctrl_q[2:1] == 2'b10 ? r1_q : {am_q[7:0], am_q[15:8]};
    Wb_Rd     = rd_q;
    Wb_Enable = ctrl_q[15] & ctrl_q[0] & ~halt_q;
    commit    = ctrl_q[15] & ~SpecialChangeMEMWB & ~halt_q;
    Ra_Data   = Ra_Addr == 4'd0 ? 16'd0 : (Wb_Enable && Wb_Rd == Ra_Addr) ? Wb_Data : rf_q[Ra_Addr];
    Rb_Data   = Rb_Addr == 4'd0 ? 16'd0 : (Wb_Enable && Wb_Rd == Rb_Addr) ? Wb_Data : rf_q[Rb_Addr];
    Halted        = halt_q;
    Retired_Count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rest) begin
      ctrl_q <= '0;
      r1_q   <= '0;
      am_q   <= '0;
      add_q  <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      if (FlushMEMWB) begin
        ctrl_q <= '0;
        r1_q   <= '0;
        am_q   <= '0;
        add_q  <= '0;
        rd_q   <= '0;
      end else if (!SpecialChangeMEMWB) begin
        ctrl_q <= Controll_Signal_In;
        r1_q   <= Read1_In;
        am_q   <= AluOrMem_In;
        add_q  <= Adder_Result_In;
        rd_q   <= Rd_In;
      end
      if (commit) begin
        if (ctrl_q[0] && rd_q != 4'd0) rf_q[rd_q] <= Wb_Data;
        cnt_q <= cnt_q + 16'd1;
        if (ctrl_q[3]) halt_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage with a reference model of commit, halt and counter
module tb_wb_stage;
  logic        clk = 0, rest = 0, hold = 0, flush = 0;
  logic [15:0] ctrl = 0, r1 = 0, am = 0, add = 0;
  logic [3:0]  rd = 0, ra = 0, rb = 0;
  logic [15:0] ra_d, rb_d, wdat, cnt;
  logic [3:0]  wrd;
  logic        wen, halted;
  int checks = 0, fails = 0;
  typedef struct {logic v, rw, h; logic [3:0] rd; logic [15:0] data;} ins_t;
  ins_t sbq[$];
  ins_t cur = '{default: 0}, e;
  logic [15:0] rf_m [16];
  logic [15:0] cnt_m = 0, s;
  logic        halted_m = 0;
  wb_stage dut (
    .clk(clk), .rest(rest), .SpecialChangeMEMWB(hold), .FlushMEMWB(flush),
    .Controll_Signal_In(ctrl), .Read1_In(r1), .AluOrMem_In(am), .Adder_Result_In(add),
    .Rd_In(rd), .Ra_Addr(ra), .Rb_Addr(rb), .Ra_Data(ra_d), .Rb_Data(rb_d),
    .Wb_Enable(wen), .Wb_Rd(wrd), .Wb_Data(wdat), .Halted(halted), .Retired_Count(cnt)
  );
  always #5 clk = ~clk;
  function automatic ins_t model_in();
    ins_t n;
    n.v = ctrl[15];
    n.rw = ctrl[0];
    n.h = ctrl[3];
    n.rd = rd;
    case (ctrl[2:1])
      2'b00: n.data = am;
      2'b01: n.data = add;
      2'b10: n.data = r1;
      default: n.data = {am[7:0], am[15:8]};
    endcase
    return n;
  endfunction
  task automatic load(input logic [15:0] c, a1, a2, a3, input logic [3:0] d);
    ctrl = c; r1 = a1; am = a2; add = a3; rd = d; hold = 0; flush = 0;
    sbq.push_back(model_in());
  endtask
  task automatic tick();
    if (!rest) begin
      cur = '{default: 0};
      for (int i = 0; i < 16; i++) rf_m[i] = 0;
      cnt_m = 0;
      halted_m = 0;
    end else begin
      if (cur.v && !hold && !halted_m) begin
        if (cur.rw && cur.rd != 0) rf_m[cur.rd] = cur.data;
        cnt_m = cnt_m + 16'd1;
        if (cur.h) halted_m = 1;
      end
      if (flush) cur = '{default: 0};
      else if (!hold) cur = model_in();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic pop_check(input string name);
    checks++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got wb_data=%h", name, wdat);
    end else begin
      e = sbq.pop_front();
      if (wdat !== e.data || wrd !== e.rd || wen !== (e.v & e.rw & ~halted_m)) begin
        fails++;
        $display("FAIL %s: got en=%b rd=%h data=%h, want en=%b rd=%h data=%h",
                 name, wen, wrd, wdat, e.v & e.rw & ~halted_m, e.rd, e.data);
      end
    end
  endtask
  task automatic test_reset();
    rest = 0; ctrl = 16'h8001; am = 16'h5A5A; rd = 4'd4; ra = 4'd4; rb = 4'd1;
    tick();
    rest = 1;
    checks++;
    if ({wen, wrd, wdat, halted, cnt, ra_d, rb_d} !== '0) begin
      fails++;
      $display("FAIL reset: got en=%b rd=%h data=%h halted=%b cnt=%h ra=%h rb=%h, want all 0",
               wen, wrd, wdat, halted, cnt, ra_d, rb_d);
    end
  endtask
  task automatic test_back_to_back();
    load(16'h8003, 16'h0, 16'h0, 16'h1234, 4'd5);
    tick();
    pop_check("b2b_first");
    load(16'h8007, 16'h0, 16'hAB12, 16'h0, 4'd6);
    ra = 4'd6;
    tick();
    pop_check("b2b_second");
    checks++;
    if (ra_d !== 16'h12AB) begin fails++; $display("FAIL b2b_bypass: got %h want 12ab", ra_d); end
    load(16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
    tick();
    pop_check("b2b_bubble");
    ra = 4'd5; rb = 4'd6;
    #1;
    checks++;
    if (ra_d !== 16'h1234 || rb_d !== 16'h12AB || cnt !== 16'd2) begin
      fails++;
      $display("FAIL b2b_rf: got r5=%h r6=%h cnt=%h want 1234 12ab 0002", ra_d, rb_d, cnt);
    end
  endtask
  task automatic test_r0();
    s = cnt_m;
    load(16'h8001, 16'h0, 16'hFFFF, 16'h0, 4'd0);
    ra = 4'd0;
    tick();
    pop_check("r0_inflight");
    checks++;
    if (ra_d !== 16'h0 || wen !== 1'b1) begin fails++; $display("FAIL r0_read: got ra=%h en=%b want 0000 1", ra_d, wen); end
    load(16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
    tick();
    pop_check("r0_bubble");
    checks++;
    if (ra_d !== 16'h0 || cnt !== s + 16'd1) begin
      fails++;
      $display("FAIL r0_after: got ra=%h cnt=%h want 0000 %h", ra_d, cnt, s + 16'd1);
    end
  endtask
  task automatic test_hold();
    load(16'h8001, 16'h0, 16'h0042, 16'h0, 4'd3);
    tick();
    pop_check("hold_load");
    s = cnt_m;
    hold = 1; ctrl = 16'h8001; am = 16'h9999; rd = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wdat !== 16'h0042 || cnt !== s) begin
        fails++;
        $display("FAIL hold_cycle%0d: got data=%h cnt=%h want 0042 %h", i, wdat, cnt, s);
      end
    end
    load(16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
    tick();
    pop_check("hold_release");
    ra = 4'd3;
    tick();
    checks++;
    if (cnt !== s + 16'd1 || ra_d !== 16'h0042) begin
      fails++;
      $display("FAIL hold_commit: got cnt=%h r3=%h want %h 0042", cnt, ra_d, s + 16'd1);
    end
  endtask
  task automatic test_flush_hold();
    load(16'h8001, 16'h0, 16'h0077, 16'h0, 4'd9);
    tick();
    pop_check("flush_load");
    s = cnt_m;
    hold = 1; flush = 1; ctrl = 16'h8001; am = 16'h5555; rd = 4'd10;
    tick();
    hold = 0; flush = 0; ctrl = 16'h0;
    checks++;
    if (wen !== 1'b0 || cnt !== s) begin
      fails++;
      $display("FAIL flush_hold: got en=%b cnt=%h want 0 %h", wen, cnt, s);
    end
    ra = 4'd9; rb = 4'd10;
    tick();
    checks++;
    if (cnt !== s || ra_d !== 16'h0 || rb_d !== 16'h0) begin
      fails++;
      $display("FAIL flush_bubble: got cnt=%h r9=%h r10=%h want %h 0000 0000", cnt, ra_d, rb_d, s);
    end
    load(16'h8001, 16'h0, 16'h0066, 16'h0, 4'd11);
    tick();
    pop_check("flush_only_load");
    flush = 1; ctrl = 16'h8001; am = 16'h3333; rd = 4'd12; ra = 4'd11;
    tick();
    flush = 0; ctrl = 16'h0;
    checks++;
    if (wen !== 1'b0 || cnt !== s + 16'd1 || ra_d !== 16'h0066) begin
      fails++;
      $display("FAIL flush_commit: got en=%b cnt=%h r11=%h want 0 %h 0066", wen, cnt, ra_d, s + 16'd1);
    end
  endtask
  task automatic test_wrap();
    ctrl = 16'h0; hold = 0; flush = 0;
    tick();
    s = cnt_m;
    ctrl = 16'h8000; am = 16'hBEEF; rd = 4'd5;
    for (int i = 0; i < 65536; i++) tick();
    ctrl = 16'h0;
    tick();
    ra = 4'd5; rb = 4'd6;
    #1;
    checks++;
    if (cnt !== s || cnt_m !== s || ra_d !== 16'h1234 || rb_d !== 16'h12AB) begin
      fails++;
      $display("FAIL wrap: got cnt=%h r5=%h r6=%h want %h 1234 12ab", cnt, ra_d, rb_d, s);
    end
  endtask
  task automatic test_halt();
    load(16'h8009, 16'h0, 16'h0BAD, 16'h0, 4'd7);
    tick();
    pop_check("halt_load");
    load(16'h8001, 16'h0, 16'h1111, 16'h0, 4'd8);
    tick();
    pop_check("halt_next");
    s = cnt_m;
    checks++;
    if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag: got %b want 1", halted); end
    load(16'h8001, 16'h0, 16'h2222, 16'h0, 4'd8);
    tick();
    pop_check("halt_more");
    ra = 4'd7; rb = 4'd8;
    tick();
    checks++;
    if (ra_d !== 16'h0BAD || rb_d !== 16'h0 || cnt !== s || wen !== 1'b0) begin
      fails++;
      $display("FAIL halt_state: got r7=%h r8=%h cnt=%h en=%b want 0bad 0000 %h 0", ra_d, rb_d, cnt, wen, s);
    end
    rest = 0; ctrl = 16'h0;
    tick();
    rest = 1;
    ra = 4'd7; rb = 4'd5;
    #1;
    checks++;
    if (halted !== 1'b0 || cnt !== 16'h0 || ra_d !== 16'h0 || rb_d !== 16'h0) begin
      fails++;
      $display("FAIL halt_reset: got halted=%b cnt=%h r7=%h r5=%h want 0 0000 0000 0000", halted, cnt, ra_d, rb_d);
    end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_r0();
    test_hold();
    test_flush_hold();
    test_wrap();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
